// File: rtl/calc_sequencer.sv
// Key-entry sequencer for the signed integer calculator: gathers operands and
// operator from decoded keys, runs the calculator for a fixed latency, owns the display.
module calc_sequencer #(
    parameter int RESULT_LAT = 2,
    parameter int MAX_DIGITS = 6
) (
    input  logic               sw_clk,
    input  logic               rst,
    input  logic               key_valid,
    input  logic [4:0]         key_code,
    output logic               key_ready,
    output logic signed [31:0] operand1,
    output logic signed [31:0] operand2,
    output logic [2:0]         operator,
    input  logic [31:0]        ans,
    output logic [31:0]        disp,
    output logic               busy,
    output logic [2:0]         state_dbg
);
    // Handshake: a key is consumed on a rising sw_clk edge where key_valid and
    // key_ready are both high; a key offered while key_ready is low is lost.
    localparam logic [2:0] ENTER_A = 3'd0;
    localparam logic [2:0] ENTER_B = 3'd1;
    localparam logic [2:0] EXEC    = 3'd2;
    localparam logic [2:0] SHOW    = 3'd3;
    localparam logic [2:0] ERROR   = 3'd4;

    logic [2:0]  state;
    logic [31:0] mag;
    logic        neg;
    logic [3:0]  dcnt;
    logic        got;
    logic [2:0]  pend;
    logic [7:0]  cnt;

    logic        take, k_digit, k_eq, k_op, k_clr, k_neg, can_dig, ans_err;
    logic [2:0]  op_k;
    logic [3:0]  dcnt_dig;
    logic [31:0] dig, mag_dig, acc;

    assign key_ready = (state != EXEC);
    assign busy      = (state == EXEC);
    assign state_dbg = state;
    assign take      = key_valid && key_ready;
    assign k_digit   = (key_code <= 5'd9);
    assign k_eq      = (key_code == 5'd10);
    assign k_op      = (key_code >= 5'd11) && (key_code <= 5'd15);
    assign k_clr     = (key_code == 5'd16);
    assign k_neg     = (key_code == 5'd17);
    assign op_k      = 3'(key_code - 5'd10);
    assign dig       = {27'd0, key_code};
    assign mag_dig   = mag * 32'd10 + dig;
    assign acc       = neg ? -mag : mag;
    assign can_dig   = (dcnt < 4'(MAX_DIGITS));
    // A zero typed onto an empty magnitude is a leading zero and uses no digit slot.
    assign dcnt_dig  = ((mag == 32'd0) && (key_code == 5'd0)) ? dcnt : dcnt + 4'd1;
    assign ans_err   = (ans == 32'h00EE0000) || (ans == 32'h00CC0000);

    always_ff @(posedge sw_clk or negedge rst) begin
        if (!rst) begin
            state    <= ENTER_A;
            operand1 <= '0;
            operand2 <= '0;
            operator <= '0;
            disp     <= '0;
            mag      <= '0;
            neg      <= 1'b0;
            dcnt     <= '0;
            got      <= 1'b0;
            pend     <= '0;
            cnt      <= '0;
        end else if (state == EXEC) begin
            if (cnt == 8'(RESULT_LAT)) begin
                cnt      <= '0;
                disp     <= ans;
                operand1 <= ans;
                if (ans_err) begin
                    state <= ERROR;
                end else if (pend != 3'd0) begin
                    operator <= pend;
                    mag      <= '0;
                    neg      <= 1'b0;
                    dcnt     <= '0;
                    got      <= 1'b0;
                    state    <= ENTER_B;
                end else begin
                    state <= SHOW;
                end
            end else begin
                cnt <= cnt + 8'd1;
            end
        end else if (take) begin
            if (k_clr) begin
                state    <= ENTER_A;
                operand1 <= '0;
                operand2 <= '0;
                operator <= '0;
                disp     <= '0;
                mag      <= '0;
                neg      <= 1'b0;
                dcnt     <= '0;
                got      <= 1'b0;
                pend     <= '0;
            end else begin
                case (state)
                    ENTER_A, ENTER_B: begin
                        if (k_digit) begin
                            got <= 1'b1;
                            if (can_dig) begin
                                mag  <= mag_dig;
                                dcnt <= dcnt_dig;
                                disp <= neg ? -mag_dig : mag_dig;
                            end
                        end else if (k_neg) begin
                            if (mag != 32'd0) begin
                                neg  <= !neg;
                                disp <= neg ? mag : -mag;
                            end
                        end else if (k_op) begin
                            if (state == ENTER_A) begin
                                operand1 <= acc;
                                operator <= op_k;
                                mag      <= '0;
                                neg      <= 1'b0;
                                dcnt     <= '0;
                                got      <= 1'b0;
                                state    <= ENTER_B;
                            end else if (!got) begin
                                operator <= op_k;
                            end else begin
                                operand2 <= acc;
                                pend     <= op_k;
                                mag      <= '0;
                                neg      <= 1'b0;
                                dcnt     <= '0;
                                state    <= EXEC;
                            end
                        end else if (k_eq) begin
                            if (state == ENTER_A) begin
                                disp <= acc;
                            end else begin
                                operand2 <= acc;
                                pend     <= '0;
                                mag      <= '0;
                                neg      <= 1'b0;
                                dcnt     <= '0;
                                state    <= EXEC;
                            end
                        end
                    end
                    SHOW: begin
                        if (k_digit) begin
                            mag   <= dig;
                            neg   <= 1'b0;
                            dcnt  <= (key_code != 5'd0) ? 4'd1 : 4'd0;
                            disp  <= dig;
                            state <= ENTER_A;
                        end else if (k_op) begin
                            operator <= op_k;
                            mag      <= '0;
                            neg      <= 1'b0;
                            dcnt     <= '0;
                            got      <= 1'b0;
                            state    <= ENTER_B;
                        end else if (k_eq) begin
                            pend  <= '0;
                            state <= EXEC;
                        end
                    end
                    ERROR: begin
                        if (k_digit) begin
                            mag   <= dig;
                            neg   <= 1'b0;
                            dcnt  <= (key_code != 5'd0) ? 4'd1 : 4'd0;
                            disp  <= dig;
                            state <= ENTER_A;
                        end
                    end
                    default: state <= ENTER_A;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: a latency-accurate calculator stand-in drives ans, and a
// key-level reference model predicts every output after each key press.
module tb_calc_sequencer;
  localparam int RL   = 2;
  localparam int MAXD = 6;
  localparam logic [31:0] ERR_CODE  = 32'h00EE0000;
  localparam logic [31:0] NULL_CODE = 32'h00CC0000;
  localparam int S_A = 0, S_B = 1, S_X = 2, S_SHOW = 3, S_ERR = 4;

  logic        sw_clk = 1'b0;
  logic        rst, key_valid, key_ready, busy;
  logic [4:0]  key_code;
  logic [31:0] operand1, operand2, disp, ans;
  logic [2:0]  operator, state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  int          m_st;
  logic [31:0] m_mag, m_op1, m_op2, m_disp;
  bit          m_neg, m_got;
  int          m_dcnt;
  logic [2:0]  m_op, m_pend;

  always #5 sw_clk = ~sw_clk;

  calc_sequencer #(.RESULT_LAT(RL), .MAX_DIGITS(MAXD)) dut (
    .sw_clk(sw_clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .key_ready(key_ready), .operand1(operand1), .operand2(operand2),
    .operator(operator), .ans(ans), .disp(disp), .busy(busy), .state_dbg(state_dbg)
  );

  function automatic logic [31:0] calc(input logic signed [31:0] a, input logic signed [31:0] b,
                                       input logic [2:0] op);
    case (op)
      3'd1: return a * b;
      3'd2: return (b == 0) ? ERR_CODE : (b == -1) ? -a : a / b;
      3'd3: return a + b;
      3'd4: return a - b;
      3'd5: return (b == 0) ? NULL_CODE : (b == -1) ? 32'd0 : a % b;
      default: return b;
    endcase
  endfunction

  // Calculator stand-in: result appears RL cycles after its inputs settle.
  logic [31:0] pipe [RL];
  always_ff @(posedge sw_clk) begin
    pipe[0] <= calc(operand1, operand2, operator);
    for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
  end
  assign ans = pipe[RL-1];

  function automatic logic [31:0] m_acc();
    return m_neg ? -m_mag : m_mag;
  endfunction

  task automatic m_reset();
    m_st = S_A; m_mag = 0; m_neg = 0; m_dcnt = 0; m_got = 0;
    m_op1 = 0; m_op2 = 0; m_disp = 0; m_op = 0; m_pend = 0;
  endtask

  task automatic m_clear_acc();
    m_mag = 0; m_neg = 0; m_dcnt = 0;
  endtask

  task automatic m_restart(input int d);
    m_mag = d; m_neg = 0; m_dcnt = (d != 0) ? 1 : 0; m_disp = d; m_st = S_A;
  endtask

  task automatic model_key(input int c, output bit go);
    go = 0;
    if (c >= 18) return;
    if (c == 16) begin m_reset(); return; end
    case (m_st)
      S_ERR:  if (c <= 9) m_restart(c);
      S_SHOW: begin
        if (c <= 9) m_restart(c);
        else if (c >= 11 && c <= 15) begin
          m_op = 3'(c - 10); m_clear_acc(); m_got = 0; m_st = S_B;
        end else if (c == 10) begin m_pend = 0; go = 1; end
      end
      default: begin
        if (c <= 9) begin
          if (m_st == S_B) m_got = 1;
          if (m_dcnt < MAXD) begin
            if (!(m_mag == 0 && c == 0)) m_dcnt++;
            m_mag = m_mag * 10 + c;
            m_disp = m_acc();
          end
        end else if (c == 17) begin
          if (m_mag != 0) begin m_neg = !m_neg; m_disp = m_acc(); end
        end else if (c >= 11 && c <= 15) begin
          if (m_st == S_A) begin
            m_op1 = m_acc(); m_op = 3'(c - 10); m_clear_acc(); m_got = 0; m_st = S_B;
          end else if (!m_got) m_op = 3'(c - 10);
          else begin m_op2 = m_acc(); m_pend = 3'(c - 10); go = 1; end
        end else if (c == 10) begin
          if (m_st == S_A) m_disp = m_acc();
          else begin m_op2 = m_acc(); m_pend = 0; go = 1; end
        end
      end
    endcase
    if (go) begin m_clear_acc(); m_st = S_X; end
  endtask

  task automatic model_exec();
    logic [31:0] r;
    r = calc(m_op1, m_op2, m_op);
    m_disp = r; m_op1 = r;
    if (r == ERR_CODE || r == NULL_CODE) m_st = S_ERR;
    else if (m_pend != 0) begin m_op = m_pend; m_clear_acc(); m_got = 0; m_st = S_B; end
    else m_st = S_SHOW;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "/op1"}, operand1, m_op1);
    check({tag, "/op2"}, operand2, m_op2);
    check({tag, "/oper"}, 32'(operator), 32'(m_op));
    check({tag, "/disp"}, disp, m_disp);
    check({tag, "/busy"}, 32'(busy), 32'(0));
    check({tag, "/ready"}, 32'(key_ready), 32'(1));
    check({tag, "/state"}, 32'(state_dbg), m_st);
  endtask

  // Present one key for one cycle (called at a falling edge); if it starts an
  // operation, optionally offer intr_code during EXEC cycle intr_at.
  task automatic press(input int c, input int intr_at, input logic [4:0] intr_code);
    bit go;
    int n;
    key_valid = 1'b1; key_code = 5'(c);
    @(negedge sw_clk);
    key_valid = 1'b0; key_code = 5'($urandom);
    model_key(c, go);
    if (go) begin
      n = 0;
      while (busy === 1'b1 && n < 40) begin
        if (n == intr_at) begin
          key_valid = 1'b1; key_code = intr_code;
          check("exec_key_ready", 32'(key_ready), 32'(0));
        end else key_valid = 1'b0;
        n++;
        @(negedge sw_clk);
      end
      key_valid = 1'b0;
      check("exec_cycles", n, RL + 1);
      model_exec();
    end
    check_all($sformatf("key%0d", c));
  endtask

  task automatic p(input int c);
    press(c, -1, 5'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, c, intr;
    rst = 1'b0; key_valid = 1'b0; key_code = 5'd0;
    m_reset();
    repeat (2) @(negedge sw_clk);
    check_all("reset");
    rst = 1'b1;
    @(negedge sw_clk);

    // 1: 12 + 3 =
    p(1); p(2); p(13); p(3);
    check("t1_op1", operand1, 32'd12);
    p(10);
    check("t1_disp", disp, 32'd15);
    check("t1_op2", operand2, 32'd3);
    check("t1_oper", 32'(operator), 32'd3);

    // 2: chained 5 * 4 - 2 =
    p(16); p(5); p(11); p(4); p(14);
    check("t2_disp_first", disp, 32'd20);
    check("t2_oper_chain", 32'(operator), 32'd4);
    p(2); p(10);
    check("t2_disp_final", disp, 32'd18);

    // 3: divide by zero -> error, op ignored, digit recovers
    p(16); p(7); p(12); p(0); p(10);
    check("t3_disp_err", disp, ERR_CODE);
    p(13);
    check("t3_err_hold", disp, ERR_CODE);
    p(3);
    check("t3_recover", disp, 32'd3);

    // 4: digit limit, negate, clear
    p(16);
    for (int d = 1; d <= 7; d++) p(d);
    check("t4_limit", disp, 32'd123456);
    p(17);
    check("t4_negate", disp, 32'(-123456));
    p(16);
    check("t4_clear", disp, 32'd0);

    // 5: keys offered during EXEC (including its exit cycle) are dropped
    p(4); p(13); p(5);
    press(10, 1, 5'd9);
    check("t5_disp", disp, 32'd9);
    press(10, RL, 5'd16);
    check("t5_repeat", disp, 32'd14);

    // 6: reset in the middle of EXEC
    p(16); p(1); p(13); p(2);
    key_valid = 1'b1; key_code = 5'd10;
    @(negedge sw_clk);
    key_valid = 1'b0;
    @(negedge sw_clk);
    check("t6_busy_before", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    m_reset();
    check_all("t6_rst_now");
    @(negedge sw_clk);
    rst = 1'b1;
    repeat (RL + 4) @(negedge sw_clk);
    check_all("t6_after");

    // Randomized key stream
    for (int k = 0; k < 250; k++) begin
      repeat ($urandom_range(0, 2)) begin
        key_code = 5'($urandom);
        @(negedge sw_clk);
      end
      r = $urandom_range(0, 99);
      if (r < 50)      c = $urandom_range(0, 9);
      else if (r < 72) c = $urandom_range(11, 15);
      else if (r < 84) c = 10;
      else if (r < 90) c = 17;
      else if (r < 94) c = 16;
      else             c = $urandom_range(18, 31);
      intr = ($urandom_range(0, 3) == 0) ? $urandom_range(0, RL) : -1;
      press(c, intr, 5'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
